// File: rtl/opcode_decoder_seq.sv
// Registered opcode decoder with a one-hot instruction sequence counter.
// Flags illegal opcodes (single-cycle pulse) and counter overrun (sticky timeout).
module opcode_decoder_seq #(
    parameter int unsigned                OPCODE_W   = 3,
    parameter logic [2**OPCODE_W-1:0]     LEGAL_MASK = '1,
    parameter int unsigned                SC_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_W-1:0]       in_opcode,
    input  logic                      in_indirect,
    input  logic                      sc_clr,
    input  logic                      timeout_clr,
    output logic [2**OPCODE_W-1:0]    decoded,
    output logic                      indirect_q,
    output logic [2**SC_W-1:0]        timing,
    output logic                      busy,
    output logic                      illegal,
    output logic                      timeout
);

    localparam int unsigned DEC_W = 2**OPCODE_W;
    localparam int unsigned TIM_W = 2**SC_W;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [SC_W-1:0]     sc_q, sc_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                ind_q, ind_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;
    logic                accept;
    logic                legal;
    logic                overrun;

    assign in_ready = (state_q == IDLE) ? 1'b1 : sc_clr;
    assign accept   = in_valid & in_ready;
    assign legal    = LEGAL_MASK[in_opcode];
    assign overrun  = (state_q == ACTIVE) && !sc_clr && (sc_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sc_q      <= '0;
            op_q      <= '0;
            ind_q     <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            op_q      <= op_d;
            ind_q     <= ind_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        op_d      = op_q;
        ind_d     = ind_q;
        illegal_d = 1'b0;
        timeout_d = timeout_q;

        if (state_q == ACTIVE) begin
            if (sc_clr || overrun) begin
                state_d = IDLE;
                sc_d    = '0;
                op_d    = '0;
                ind_d   = 1'b0;
            end else begin
                sc_d = sc_q + 1'b1;
            end
        end

        // Accept overrides the completion path so back-to-back loads have no bubble.
        if (accept) begin
            illegal_d = !legal;
            sc_d      = '0;
            if (legal) begin
                state_d = ACTIVE;
                op_d    = in_opcode;
                ind_d   = in_indirect;
            end else begin
                state_d = IDLE;
                op_d    = '0;
                ind_d   = 1'b0;
            end
        end

        if (overrun) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_comb begin
        decoded = '0;
        timing  = '0;
        for (int unsigned i = 0; i < DEC_W; i++) begin
            decoded[i] = (state_q == ACTIVE) && (op_q == OPCODE_W'(i));
        end
        for (int unsigned i = 0; i < TIM_W; i++) begin
            timing[i] = (state_q == ACTIVE) && (sc_q == SC_W'(i));
        end
    end

    assign busy       = (state_q == ACTIVE);
    assign indirect_q = ind_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_opcode_decoder_seq.sv
// Directed self-checking bench for opcode_decoder_seq (opcode 7 configured illegal).
module tb_opcode_decoder_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic        in_indirect;
    logic        sc_clr;
    logic        timeout_clr;
    logic [7:0]  decoded;
    logic        indirect_q;
    logic [15:0] timing;
    logic        busy;
    logic        illegal;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    opcode_decoder_seq #(
        .OPCODE_W   (3),
        .LEGAL_MASK (8'h7F),
        .SC_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_indirect (in_indirect),
        .sc_clr      (sc_clr),
        .timeout_clr (timeout_clr),
        .decoded     (decoded),
        .indirect_q  (indirect_q),
        .timing      (timing),
        .busy        (busy),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".decoded"}, 32'(decoded), 32'h0);
        check({tag, ".timing"},  32'(timing),  32'h0);
        check({tag, ".busy"},    32'(busy),    32'h0);
        check({tag, ".ready"},   32'(in_ready), 32'h1);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_opcode   = 3'h0;
        in_indirect = 1'b0;
        sc_clr      = 1'b0;
        timeout_clr = 1'b0;
        #23;
        check_idle("reset");
        check("reset.illegal", 32'(illegal), 32'h0);
        check("reset.timeout", 32'(timeout), 32'h0);
        check("reset.ind",     32'(indirect_q), 32'h0);
        rst_n = 1'b1;
        step();

        // Accept op 5 with I=1, then watch timing advance.
        in_valid = 1'b1; in_opcode = 3'h5; in_indirect = 1'b1;
        step();
        check("acc.decoded", 32'(decoded), 32'h20);
        check("acc.ind",     32'(indirect_q), 32'h1);
        check("acc.t0",      32'(timing), 32'h0001);
        check("acc.busy",    32'(busy), 32'h1);
        check("acc.ready",   32'(in_ready), 32'h0);
        // in_valid held while busy must not be sampled
        in_opcode = 3'h4; in_indirect = 1'b0;
        step();
        check("acc.t1",       32'(timing), 32'h0002);
        check("acc.hold_dec", 32'(decoded), 32'h20);
        check("acc.hold_ind", 32'(indirect_q), 32'h1);
        in_valid = 1'b0;
        step();
        check("acc.t2", 32'(timing), 32'h0004);
        step();
        check("acc.t3", 32'(timing), 32'h0008);

        // Back-to-back at T3.
        sc_clr = 1'b1; in_valid = 1'b1; in_opcode = 3'h2; in_indirect = 1'b0;
        #1;
        check("b2b.ready", 32'(in_ready), 32'h1);
        step();
        sc_clr = 1'b0; in_valid = 1'b0;
        check("b2b.decoded", 32'(decoded), 32'h04);
        check("b2b.t0",      32'(timing), 32'h0001);
        check("b2b.ind",     32'(indirect_q), 32'h0);
        check("b2b.busy",    32'(busy), 32'h1);

        // in_valid=0 in ACTIVE keeps advancing; sc_clr ends; sc_clr in IDLE is a no-op.
        step();
        check("adv.t1", 32'(timing), 32'h0002);
        sc_clr = 1'b1;
        step();
        check_idle("clr");
        step();
        check_idle("clr_idle");
        sc_clr = 1'b0;

        // Illegal opcode 7.
        in_valid = 1'b1; in_opcode = 3'h7; in_indirect = 1'b1;
        step();
        in_valid = 1'b0;
        check("ill.pulse", 32'(illegal), 32'h1);
        check("ill.ind",   32'(indirect_q), 32'h0);
        check_idle("ill");
        step();
        check("ill.end", 32'(illegal), 32'h0);

        // Overrun with op 0.
        in_valid = 1'b1; in_opcode = 3'h0; in_indirect = 1'b0;
        step();
        in_valid = 1'b0;
        check("ovr.decoded", 32'(decoded), 32'h01);
        check("ovr.t0",      32'(timing), 32'h0001);
        for (int i = 0; i < 15; i++) step();
        check("ovr.t15",      32'(timing), 32'h8000);
        check("ovr.busy15",   32'(busy), 32'h1);
        check("ovr.pre_to",   32'(timeout), 32'h0);
        step();
        check("ovr.timeout", 32'(timeout), 32'h1);
        check_idle("ovr");
        step();
        check("ovr.sticky", 32'(timeout), 32'h1);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check("ovr.cleared", 32'(timeout), 32'h0);

        // Set wins over a simultaneous clear.
        in_valid = 1'b1; in_opcode = 3'h1;
        step();
        in_valid = 1'b0;
        check("swin.decoded", 32'(decoded), 32'h02);
        for (int i = 0; i < 15; i++) step();
        check("swin.t15", 32'(timing), 32'h8000);
        timeout_clr = 1'b1;
        step();
        check("swin.timeout", 32'(timeout), 32'h1);
        step();
        timeout_clr = 1'b0;
        check("swin.cleared", 32'(timeout), 32'h0);

        // Asynchronous reset mid-ACTIVE.
        in_valid = 1'b1; in_opcode = 3'h3; in_indirect = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("ar.t1", 32'(timing), 32'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("ar");
        check("ar.ind", 32'(indirect_q), 32'h0);
        #3;
        rst_n = 1'b1;
        step();
        check_idle("ar_post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
